// File: rtl/ofifo_multi.sv
// Column-aligned output FIFO: each column writes independently, reads pop one aligned row.
// First-word-fall-through output with occupancy level, almost-full and sticky error flags.
module ofifo_multi #(
    parameter int unsigned col       = 8,
    parameter int unsigned bw        = 4,
    parameter int unsigned depth     = 64,
    parameter int unsigned af_margin = 4,
    localparam int unsigned AW       = $clog2(depth),
    localparam int unsigned CW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [col-1:0]    wr,
    input  logic [col*bw-1:0] in,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_ready,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [CW-1:0]     o_level,
    output logic              o_ovf,
    output logic              o_udf
);

    localparam logic [CW-1:0] DepthC = CW'(depth);
    localparam logic [CW-1:0] AfThr  = CW'(depth - af_margin);

    logic [AW-1:0] r_wptr [col];
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt  [col];
    logic [bw-1:0] r_mem  [col][depth];
    logic          r_ovf;
    logic          r_udf;

    logic           w_valid;
    logic           w_ready;
    logic           w_full;
    logic           w_af;
    logic [CW-1:0]  w_level;
    logic           w_rd_acc;
    logic [col-1:0] w_wr_acc;
    logic           w_drop;

    // Flags derive only from registered counts, never from this cycle's strobes.
    always_comb begin
        w_valid = 1'b1;
        w_ready = 1'b1;
        w_full  = 1'b1;
        w_af    = 1'b0;
        w_level = DepthC;
        for (int i = 0; i < col; i++) begin
            if (r_cnt[i] == '0) w_valid = 1'b0;
            if (r_cnt[i] == DepthC) w_ready = 1'b0;
            else                    w_full  = 1'b0;
            if (r_cnt[i] >= AfThr) w_af = 1'b1;
            if (r_cnt[i] < w_level) w_level = r_cnt[i];
        end
    end

    assign w_rd_acc = rd & w_valid & ~flush;

    // A full column may still accept when the same cycle pops a row.
    always_comb begin
        w_wr_acc = '0;
        for (int i = 0; i < col; i++) begin
            w_wr_acc[i] = wr[i] & ~flush & ((r_cnt[i] < DepthC) | w_rd_acc);
        end
    end

    assign w_drop = ~flush & |(wr & ~w_wr_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            for (int i = 0; i < col; i++) begin
                r_wptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else if (flush) begin
            r_rptr <= '0;
            for (int i = 0; i < col; i++) begin
                r_wptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            if (w_drop) r_ovf <= 1'b1;
            if (rd && !w_valid) r_udf <= 1'b1;
            for (int i = 0; i < col; i++) begin
                if (w_wr_acc[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                r_cnt[i] <= r_cnt[i] + CW'(w_wr_acc[i]) - CW'(w_rd_acc);
            end
        end
    end

    // Storage carries no reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (w_wr_acc[i]) r_mem[i][r_wptr[i]] <= in[i*bw +: bw];
        end
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < col; i++) begin
            out[i*bw +: bw] = r_mem[i][r_rptr];
        end
    end

    assign o_valid       = w_valid;
    assign o_ready       = w_ready;
    assign o_full        = w_full;
    assign o_almost_full = w_af;
    assign o_level       = w_level;
    assign o_ovf         = r_ovf;
    assign o_udf         = r_udf;

endmodule
